// File: rtl/core_fetch_pkg.sv
// ============================================================================
// Module      : structures (package)
// Description : Shared pipeline types for the fetch stage and its consumers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package structures;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] fetch_pc;
        logic [63:0] fetch_pc4;
    } IF_regs_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] FETCH_NOP = 32'h0;

    function automatic logic [63:0] word_align(input logic [63:0] addr);
        return addr & ~64'h3;
    endfunction

endpackage

`default_nettype wire

// File: rtl/core_fetch_fifo.sv
// ============================================================================
// Module      : fetch_fifo
// Description : Circular FIFO of fetched {pc, inst} entries with sync clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
    import structures::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count,
    output logic               empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    fetch_entry_t       mem_q [DEPTH];
    fetch_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/core_fetch.sv
// ============================================================================
// Module      : core_fetch
// Description : In-order instruction fetch with request credit, response FIFO,
//               stall hold and flush redirect. Define FETCH_BYPASS_EN to let a
//               response land directly in IF_regs when the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_fetch
    import structures::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0040_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [63:0] redirect_pc,
    output logic        req_valid,
    output logic [63:0] req_addr,
    input  logic        req_ready,
    input  logic        resp_valid,
    input  logic [31:0] resp_inst,
    output IF_regs_t    IF_regs
);

    localparam int              CNT_W     = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]  DEPTH_CAP = (CNT_W + 1)'(DEPTH);
    localparam IF_regs_t        IF_BUBBLE = '{inst: FETCH_NOP, fetch_pc: 64'h0, fetch_pc4: 64'h0};

    logic [63:0]        pc_q, pc_d;
    logic [63:0]        exp_pc_q, exp_pc_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    IF_regs_t           if_regs_q, if_regs_d;

    fetch_entry_t       fifo_head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;

    logic [63:0]        w_redirect;
    logic [CNT_W:0]     w_occupancy;
    logic               w_issue;
    logic               w_accept;
    logic               w_dropping;
    logic               w_live;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;

    assign w_redirect  = word_align(redirect_pc);
    // Credit covers both outstanding requests and queued words, so a response
    // always finds a free FIFO slot.
    assign w_occupancy = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign w_issue     = !flush && (w_occupancy < DEPTH_CAP);
    assign w_accept    = w_issue && req_ready;
    assign w_dropping  = (drop_q != '0);
    assign w_live      = resp_valid && !w_dropping && !flush;

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_live && fifo_empty && !stall;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = w_live && !w_bypass;
    assign w_pop  = !flush && !stall && !fifo_empty;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (flush),
        .push      (w_push),
        .push_data ('{pc: exp_pc_q, inst: resp_inst}),
        .pop       (w_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_comb begin
        pc_d       = pc_q;
        exp_pc_d   = exp_pc_q;
        inflight_d = inflight_q + CNT_W'(w_accept) - CNT_W'(resp_valid);
        drop_d     = drop_q;
        if_regs_d  = if_regs_q;
        if (flush) begin
            pc_d      = w_redirect;
            exp_pc_d  = w_redirect;
            // Everything still outstanding after this cycle belongs to the old path.
            drop_d    = inflight_q - CNT_W'(resp_valid);
            if_regs_d = IF_BUBBLE;
        end else begin
            if (w_accept) begin
                pc_d = pc_q + 64'd4;
            end
            if (w_live) begin
                exp_pc_d = exp_pc_q + 64'd4;
            end
            if (resp_valid && w_dropping) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (!stall) begin
                if (w_bypass) begin
                    if_regs_d = '{inst: resp_inst, fetch_pc: exp_pc_q, fetch_pc4: exp_pc_q + 64'd4};
                end else if (w_pop) begin
                    if_regs_d = '{inst: fifo_head.inst, fetch_pc: fifo_head.pc,
                                  fetch_pc4: fifo_head.pc + 64'd4};
                end else begin
                    if_regs_d = IF_BUBBLE;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            exp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            if_regs_q  <= IF_BUBBLE;
        end else begin
            pc_q       <= pc_d;
            exp_pc_q   <= exp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            if_regs_q  <= if_regs_d;
        end
    end

    // Request outputs read as zero while reset is held.
    assign req_valid = reset_n && w_issue;
    assign req_addr  = reset_n ? pc_q : 64'h0;
    assign IF_regs   = if_regs_q;

endmodule

`default_nettype wire

// File: tb/tb_core_fetch.sv
// ============================================================================
// Module      : tb_core_fetch
// Description : Directed self-checking bench for core_fetch with an in-order
//               variable-latency instruction memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_fetch;
    import structures::*;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_0040_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        flush;
    logic [63:0] redirect_pc;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_inst;
    IF_regs_t    IF_regs;

    always #5 clock = ~clock;

    core_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (2)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_inst   (resp_inst),
        .IF_regs     (IF_regs)
    );

    int          checks = 0;
    int          errors = 0;
    int          lat    = 1;
    int          mcyc   = 0;
    logic [63:0] next_pc;

    typedef struct {
        int          due;
        logic [63:0] addr;
    } mreq_t;
    mreq_t mq[$];

    function automatic logic [31:0] word_at(input logic [63:0] a);
        logic [15:0] n;
        n = a[17:2] + 16'd1;
        return {8'h24, n[7:0], n};
    endfunction

    // Memory: a request accepted in cycle A answers in cycle A+lat, in order.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            mcyc = 0;
            resp_valid <= 1'b0;
            resp_inst  <= '0;
        end else begin
            mcyc = mcyc + 1;
            if (req_valid && req_ready) begin
                mq.push_back('{due: mcyc - 1 + lat, addr: req_addr});
            end
            if (mq.size() > 0 && mq[0].due <= mcyc) begin
                resp_valid <= 1'b1;
                resp_inst  <= word_at(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                resp_valid <= 1'b0;
                resp_inst  <= '0;
            end
        end
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // A bubble must be all zero; anything else must be the next in-order word.
    task automatic observe(output bit got);
        got = 1'b0;
        if (IF_regs.inst === FETCH_NOP) begin
            check("bubble", IF_regs, '0);
        end else begin
            check("fetch_pc", IF_regs.fetch_pc, next_pc);
            check("fetch_pc4", IF_regs.fetch_pc4, next_pc + 64'd4);
            check("inst", IF_regs.inst, word_at(next_pc));
            next_pc = next_pc + 64'd4;
            got = 1'b1;
        end
    endtask

    task automatic expect_stream(input string tag, input int n);
        int seen;
        bit got;
        seen = 0;
        for (int c = 0; c < 20 * n && seen < n; c++) begin
            tick();
            observe(got);
            if (got) seen++;
        end
        check({tag, "_count"}, seen, n);
    endtask

    initial begin
        bit          got;
        IF_regs_t    snap;
        int          w;

        reset_n     = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        redirect_pc = '0;
        req_ready   = 1'b1;

        // Reset
        repeat (3) begin
            @(negedge clock);
            check("rst_if_regs", IF_regs, '0);
            check("rst_req_valid", req_valid, 0);
            check("rst_req_addr", req_addr, 0);
        end
        reset_n = 1'b1;
        #1;
        check("first_req_valid", req_valid, 1);
        check("first_req_addr", req_addr, RESET_PC);

        // First-instruction latency
        next_pc = RESET_PC;
        tick();
        check("lat_c1_bubble", IF_regs, '0);
        tick();
`ifdef FETCH_BYPASS_EN
        observe(got);
        check("lat_c2_first", got, 1);
`else
        check("lat_c2_bubble", IF_regs, '0);
        tick();
        observe(got);
        check("lat_c3_first", got, 1);
`endif

        // Streaming
        expect_stream("stream", 8);

        // Stall mid-stream
        stall = 1'b1;
        snap  = IF_regs;
        repeat (3) begin
            tick();
            check("stall_hold", IF_regs, snap);
            check("stall_occ_le2", (int'(dut.inflight_q) + int'(dut.fifo_count)) <= 2, 1);
        end
        stall = 1'b0;
        expect_stream("after_stall", 6);

        // Flush with two requests outstanding
        lat = 3;
        w   = 0;
        while ((mq.size() + int'(resp_valid)) != 2 && w < 50) begin
            tick();
            observe(got);
            w++;
        end
        check("two_inflight", mq.size() + int'(resp_valid), 2);
        flush       = 1'b1;
        redirect_pc = 64'h0000_0000_0080_0003;
        #1;
        check("flush_no_req", req_valid, 0);
        tick();
        flush = 1'b0;
        check("flush_if_regs", IF_regs, '0);
        check("flush_req_addr", req_addr, 64'h0000_0000_0080_0000);
        next_pc = 64'h0000_0000_0080_0000;
        expect_stream("after_flush", 5);

        // Backpressure
        lat = 1;
        expect_stream("lat1_stream", 3);
        req_ready = 1'b0;
        repeat (5) begin
            tick();
            observe(got);
        end
        repeat (4) begin
            check("bp_req_valid", req_valid, 1);
            check("bp_req_addr", req_addr, next_pc);
            tick();
            observe(got);
        end
        req_ready = 1'b1;
        expect_stream("after_bp", 4);

        // Flush and stall together
        flush       = 1'b1;
        stall       = 1'b1;
        redirect_pc = 64'h0000_0000_0012_3458;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        check("fs_if_regs", IF_regs, '0);
        check("fs_req_addr", req_addr, 64'h0000_0000_0012_3458);
        next_pc = 64'h0000_0000_0012_3458;
        expect_stream("after_fs", 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/core_fetch.md
# core_fetch

Instruction-fetch stage of the 0dMIPS pipeline and the producer of `IF_regs_t`, which the decode stage consumes. It owns the PC, issues in-order word requests to instruction memory over a valid/ready handshake, and buffers returned words with their PCs in a small FIFO. It presents one instruction per cycle to decode, holds it on `stall`, and redirects on `flush`, discarding stale in-flight responses.

## Interface
Parameters:
- `RESET_PC`, default 64'h0000_0000_0040_0000: first fetch address after reset.
- `DEPTH`, default 2: FIFO entries. This is also the cap on in-flight requests plus queued words. Must be at least 1.

Ports:
- `clock`  in  1  sole clock; all state is on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  decode hold (load-use). Hold `IF_regs` unchanged.
- `flush`  in  1  redirect (branch, jump or exception). Takes priority over `stall`.
- `redirect_pc`  in  64  target PC, sampled when `flush`=1. Bits [1:0] are forced to 0.
- `req_valid`  out  1  instruction-memory request valid.
- `req_addr`  out  64  request word address.
- `req_ready`  in  1  memory accepts the request this cycle.
- `resp_valid`  in  1  response word valid. Responses return in order, at least 1 cycle after acceptance.
- `resp_inst`  in  32  response instruction word.
- `IF_regs`  out  `IF_regs_t`  {`inst`, `fetch_pc`, `fetch_pc4`} registered to decode.

## Operation
- Registers:
  - `pc`: next request address.
  - `exp_pc`: PC of the next live response.
  - `inflight`: count of accepted requests not yet responded, range 0..DEPTH.
  - `drop`: count of in-flight responses to discard, never greater than `inflight`.
  - `count`: FIFO occupancy.
- Issue rule:
  - `req_valid` = !flush && (inflight + count < DEPTH). `req_addr` = `pc`.
  - On accept (`req_valid`&&`req_ready`): `pc` += 4 and `inflight` += 1.
  - While `req_ready`=0, `req_valid` and `req_addr` stay stable.
- Response handling:
  - On `resp_valid`, `inflight` -= 1.
  - If `drop`>0: `drop` -= 1 and the word is discarded.
  - Otherwise: push {`exp_pc`, `resp_inst`} into the FIFO and `exp_pc` += 4.
- Output update when !stall:
  - FIFO non-empty: pop the head. `IF_regs` <= {inst, pc, pc+4}.
  - FIFO empty: load a bubble, `IF_regs` <= '0 (inst 0 is sll $0 = nop).
  - When `stall`=1, `IF_regs` holds.
- Flush, checked first:
  - `pc` <= `exp_pc` <= {redirect_pc[63:2], 2'b00}.
  - The FIFO is cleared and `IF_regs` <= '0.
  - `drop` <= inflight - resp_valid. A response arriving in the flush cycle is discarded.
  - No request is issued in the flush cycle.
- Simultaneous events:
  - Push and pop in the same cycle leave `count` unchanged.
  - Accept and response in the same cycle leave `inflight` unchanged.
- Arithmetic: all 64-bit adds wrap modulo 2^64. Counters never exceed DEPTH.

## Timing
- Reset values:
  - Every output is 0 while `reset_n`=0, including `IF_regs` and `req_valid`.
  - `pc` = `exp_pc` = RESET_PC. `inflight` = `drop` = `count` = 0.
- The first cycle after reset release drives `req_valid`=1 with `req_addr`=RESET_PC.
- Latency, without bypass: response in cycle N, FIFO write at the end of N, `IF_regs` visible in cycle N+2.
- Sustained throughput: 1 instruction/cycle needs memory latency of 1 and DEPTH ≥ 2.
- Reset asserted mid-operation: all state is lost immediately. Late memory responses are the memory side's responsibility.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - A live response arriving with FIFO empty and !stall && !flush loads directly into `IF_regs` at the end of cycle N, visible in N+1.
  - That response is not pushed into the FIFO.
- Undefined: every live response goes through the FIFO.

## Structure
- Shared package `structures` gains:
  - `fetch_entry_t` {logic [63:0] pc; logic [31:0] inst;}.
  - Constant `FETCH_NOP` = 32'h0.
  - `IF_regs_t` is reused unchanged.
- One sub-module, `fetch_fifo`:
  - Parameterised by DEPTH over `fetch_entry_t`.
  - push/pop/clear, `count`, head output.
  - Circular pointers wrap at DEPTH.

## Test plan
- Reset:
  - Stimulus: `reset_n`=0 for 3 cycles, then release.
  - Required: `IF_regs`='0 and `req_valid`=0 during reset; cycle 1 after release shows `req_addr`=0x400000.
- Streaming:
  - Stimulus: `req_ready`=1, latency 1, words 0x24010001, 0x24020002, …
  - Required: `IF_regs.fetch_pc` runs 0x400000, 0x400004, … with `fetch_pc4`=`fetch_pc`+4 and `inst` matching in order.
- Stall:
  - Stimulus: `stall`=1 for 3 cycles mid-stream.
  - Required: `IF_regs` constant; `inflight`+`count` ≤ 2; after release no PC is skipped or duplicated.
- Flush with 2 in flight:
  - Stimulus: `redirect_pc`=0x800003.
  - Required: both stale words are discarded, bubbles follow, and the next non-bubble has `fetch_pc`=0x800000.
- Backpressure:
  - Stimulus: `req_ready`=0 for 4 cycles.
  - Required: `req_addr` stable and `req_valid` held; no PC advance.
- Flush plus stall in the same cycle:
  - Required: the flush behaviour applies (`IF_regs`='0, redirect taken).
  - With `FETCH_BYPASS_EN`, an empty-FIFO response appears one cycle earlier.
